vr_completer_fifo: RTL and testbench
====================================

# vr_completer_fifo

Downstream completer stage for the single-requester valid/ready link. Accepts words from the requester over a valid/ready handshake and buffers them in a small circular FIFO. Presents them to a sink over a second valid/ready handshake. Keeps an occupancy count and a saturating count of delivered words for debug and monitoring.

## Interface
- `DSIZE`, 4: data width in bits; same width as the requester data bus.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `CW`, $clog2(DEPTH)+1: width of the occupancy count.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  requester has a word on `in_data`.
- `in_data`  input  DSIZE  requester word.
- `in_ready`  output  1  completer can accept a word this cycle.
- `out_valid`  output  1  head word present on `out_data`.
- `out_data`  output  DSIZE  head-of-FIFO word.
- `out_ready`  input  1  sink accepts the head word this cycle.
- `count`  output  CW  current occupancy, 0..DEPTH.
- `xfer_cnt`  output  8  delivered words, saturating at 8'hFF.

## Operation
- Push: `in_valid && in_ready` at a rising edge.
  - Writes `in_data` to `mem[wr_ptr]`.
  - `wr_ptr` increments modulo DEPTH.
- Pop: `out_valid && out_ready` at a rising edge.
  - `rd_ptr` increments modulo DEPTH.
  - `xfer_cnt` increments unless it is already 8'hFF.
- `count` update on each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- `in_ready` = (count != DEPTH). Decoded from registered state only; no combinational path from `in_valid` or `out_ready`.
- `out_valid` = (count != 0). `out_data` = `mem[rd_ptr]`, driven combinationally from the registered pointer and array.
- Full (count == DEPTH):
  - `in_ready` = 0 even when a pop occurs the same cycle. There is no push-through-on-pop.
  - A word presented while full is not captured. The requester must hold `in_valid` and `in_data` until `in_ready` = 1.
- Empty (count == 0):
  - `out_valid` = 0. There is no bypass from input to output.
  - `out_data` is don't-care.
- Simultaneous push and pop when 0 < count < DEPTH: both take effect; `count` is unchanged; pointers advance independently.
- Pointer wrap-around: after DEPTH-1 the pointer returns to 0. Word order is strictly preserved across wrap.
- Sink rules:
  - The sink may drop `out_ready` at any time.
  - `out_valid`/`out_data` stay stable until the pop is taken.
  - Once `out_valid` is high, it never drops without a pop.
- Reset mid-operation:
  - All buffered words are discarded.
  - Pointers, `count` and `xfer_cnt` clear immediately. Memory contents are not cleared.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `count` = 0, `xfer_cnt` = 0, `out_data` = don't-care.
- Input-to-output latency: a word pushed at edge N into an empty FIFO shows `out_valid` = 1 and the word on `out_data` during the cycle after edge N. It can be popped at edge N+1.
- Throughput: one word per cycle sustained when `out_ready` is held high and the FIFO never fills.
- `in_ready` falls in the cycle after the edge that makes count == DEPTH. It rises in the cycle after the first pop from full.
- `xfer_cnt` and `count` reflect an edge's transfers in the cycle following that edge.

## Test plan
- Reset then idle: assert `rst` for 2 cycles then release; hold `in_valid` = 0.
  - Required: `in_ready` = 1, `out_valid` = 0, `count` = 0, `xfer_cnt` = 0 throughout.
- Sparse single words: push 0xB, idle, push 0xD, idle, push 0x9 (alternate `in_valid`), with `out_ready` = 1.
  - Required: `out_data` shows B, D, 9, each one cycle after its push.
  - Required: `count` never exceeds 1; `xfer_cnt` ends at 3.
- Back-to-back: push 8, 7, 6, 5 on consecutive cycles with `out_ready` = 1.
  - Required: outputs 8, 7, 6, 5 on consecutive cycles; `count` stays at 1 during the burst.
  - Required: `in_ready` never drops.
- Fill and backpressure: `out_ready` = 0; push A, B, C, D, then hold E valid.
  - Required: `count` = 4 and `in_ready` = 0; E is not taken.
  - Raise `out_ready`. Required: outputs A, B, C, D, E in order; `in_ready` returns one cycle after the first pop.
- Wrap and simultaneous ops: with `count` = 2, run 6 cycles with both push and pop asserted.
  - Required: `count` stays 2; pointers wrap past 3; output order matches input order exactly.
- Reset mid-stream: assert `rst` while `count` = 3.
  - Required: `count` = 0, `out_valid` = 0, `in_ready` = 1, `xfer_cnt` = 0.
  - Required: the next pushed word (0x1) is the first word popped afterwards.

Source files
------------

// File: rtl/vr_completer_fifo_if.sv
// Valid/ready link bundle between the requester, the completer FIFO and its sink.
// Carries both handshakes plus the completer's occupancy and delivery counters.
// Ports: master = requester/sink side (testbench), slave = completer side.
interface vr_completer_fifo_if #(
  parameter int DSIZE = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic             in_valid;
  logic [DSIZE-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic [7:0]       xfer_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, xfer_cnt
  );
endinterface

// File: rtl/vr_completer_fifo.sv
// Purpose: completer stage, buffers requester words in a DEPTH-entry circular FIFO.
// Latency: a word pushed at edge N is visible on out_data in the cycle after N.
// Backpressure: in_ready drops while full (no push-through on pop); sink may stall freely.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset (clears pointers and counters, not memory)
//   bus  - slave modport: in_valid/in_data/in_ready (requester side),
//          out_valid/out_data/out_ready (sink side), count, xfer_cnt (monitoring)
module vr_completer_fifo #(
  parameter int DSIZE = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  vr_completer_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       xfer_cnt_q, xfer_cnt_d;

  logic in_rdy;
  logic out_vld;
  logic push;
  logic pop;

  // Both flags come from the registered count only, so neither handshake
  // has a combinational path back from the other side's valid/ready.
  assign in_rdy  = (count_q != CW'(DEPTH));
  assign out_vld = (count_q != '0);

  assign push = bus.in_valid && in_rdy;
  assign pop  = out_vld && bus.out_ready;

  always_comb begin
    // DEPTH is a power of two, so plain AW-bit increment wraps modulo DEPTH.
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q;
    xfer_cnt_d = xfer_cnt_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop && (xfer_cnt_q != 8'hFF)) begin
      xfer_cnt_d = xfer_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; stale entries are unreachable
  // once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.xfer_cnt  = xfer_cnt_q;
endmodule

// File: tb/tb_vr_completer_fifo.sv
// Bench for vr_completer_fifo: directed plan with literal expectations, then
// random traffic, all checked every cycle against a queue-based reference.
module tb_vr_completer_fifo;
  localparam int DSIZE = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vr_completer_fifo_if #(.DSIZE(DSIZE), .DEPTH(DEPTH), .CW(CW)) bus ();

  vr_completer_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue, delivered-word count as an integer.
  logic [DSIZE-1:0] mq[$];
  int               m_xfer = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_xfer = 0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && (mq.size() < DEPTH);
      do_pop  = bus.out_ready && (mq.size() > 0);
      if (do_pop) begin
        void'(mq.pop_front());
        if (m_xfer < 255) m_xfer++;
      end
      if (do_push) mq.push_back(bus.in_data);
    end
  end

  // Compare process: outputs against the reference, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready),  32'(mq.size() != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("count",     32'(bus.count),     32'(mq.size()));
    chk("xfer_cnt",  32'(bus.xfer_cnt),  32'(m_xfer));
    if (mq.size() != 0) chk("out_data", 32'(bus.out_data), 32'(mq[0]));
  end

  bit last_acc;

  // Drive inputs just after a rising edge, let one edge happen, return at edge+1.
  task automatic step(input logic v, input logic [DSIZE-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(negedge clk);
    last_acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic             v;
    logic [DSIZE-1:0] d;
    logic             r;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(1'b0, 4'h0, 1'b0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_count", 32'(bus.count), 32'd0);
    chk("idle_xfer", 32'(bus.xfer_cnt), 32'd0);

    // Sparse single words
    step(1'b1, 4'hB, 1'b1); chk("sparse_B", 32'(bus.out_data), 32'hB); chk("sparse_cnt1", 32'(bus.count), 32'd1);
    step(1'b0, 4'h0, 1'b1); chk("sparse_cnt0", 32'(bus.count), 32'd0);
    step(1'b1, 4'hD, 1'b1); chk("sparse_D", 32'(bus.out_data), 32'hD);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h9, 1'b1); chk("sparse_9", 32'(bus.out_data), 32'h9);
    step(1'b0, 4'h0, 1'b1);
    chk("sparse_xfer", 32'(bus.xfer_cnt), 32'd3);

    // Back-to-back
    for (int i = 0; i < 4; i++) begin
      d = 4'(8 - i);
      step(1'b1, d, 1'b1);
      chk("b2b_data", 32'(bus.out_data), 32'(8 - i));
      chk("b2b_count", 32'(bus.count), 32'd1);
      chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    end
    step(1'b0, 4'h0, 1'b1);
    chk("b2b_xfer", 32'(bus.xfer_cnt), 32'd7);

    // Fill and backpressure
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'hB, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'hD, 1'b0);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 4'hE, 1'b0);
    chk("full_hold_count", 32'(bus.count), 32'd4);
    chk("full_hold_head", 32'(bus.out_data), 32'hA);
    step(1'b1, 4'hE, 1'b1);
    chk("pop_full_count", 32'(bus.count), 32'd3);
    chk("pop_full_in_ready", 32'(bus.in_ready), 32'd1);
    chk("pop_full_head", 32'(bus.out_data), 32'hB);
    step(1'b1, 4'hE, 1'b1); chk("drain_C", 32'(bus.out_data), 32'hC); chk("drain_cnt", 32'(bus.count), 32'd3);
    step(1'b0, 4'h0, 1'b1); chk("drain_D", 32'(bus.out_data), 32'hD);
    step(1'b0, 4'h0, 1'b1); chk("drain_E", 32'(bus.out_data), 32'hE);
    step(1'b0, 4'h0, 1'b1); chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("fill_xfer", 32'(bus.xfer_cnt), 32'd12);

    // Wrap with simultaneous push and pop
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = 4'(3 + i);
      step(1'b1, d, 1'b1);
      chk("wrap_count", 32'(bus.count), 32'd2);
      chk("wrap_head", 32'(bus.out_data), 32'(2 + i));
    end
    chk("wrap_xfer", 32'(bus.xfer_cnt), 32'd18);

    // Reset mid-stream with three words buffered
    step(1'b1, 4'h9, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_xfer", 32'(bus.xfer_cnt), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 4'h1, 1'b0);
    chk("post_rst_head", 32'(bus.out_data), 32'h1);
    step(1'b0, 4'h0, 1'b1);
    chk("post_rst_xfer", 32'(bus.xfer_cnt), 32'd1);
    chk("post_rst_count", 32'(bus.count), 32'd0);

    // Random traffic; requester holds a word until it is accepted.
    last_acc = 1'b1;
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!(v && !last_acc)) begin
        v = 1'($urandom_range(0, 3) != 0);
        d = 4'($urandom);
      end
      r = 1'($urandom_range(0, 2) != 0);
      if (i == 1500) r = 1'b0;
      step(v, d, r);
      if (i == 1200) begin
        bus.in_valid = 1'b0;
        v = 1'b0;
        #3 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    // Enough pops have occurred for the delivered-word count to have saturated.
    repeat (8) step(1'b0, 4'h0, 1'b1);
    chk("sat_xfer", 32'(bus.xfer_cnt), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
